map_ram_arbiter: RTL and testbench

Shares the single-port game map RAM between up to N_REQ requesters: player 1 movement, player 2 movement, and the bomb/explosion engine. Round-robin arbitration, one transaction at a time, with a req/ack handshake per requester. New grants are issued only while the access window `win` is high, so map updates stay out of the VGA renderer's active-video reads. It sits between the game-logic blocks and the map RAM in the DE2 FPGA game core.

---
 rtl/map_ram_arbiter.sv | 109 ++++++++++
 tb/tb_map_ram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_ram_arbiter.sv
// Round-robin arbiter sharing the single-port map RAM between game-logic requesters.
// Grants are issued only while win is high; each transaction runs ACCESS -> WAIT -> RESP.
module map_ram_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    win,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic                    ram_we,
    output logic [DATA_W-1:0]       ram_wdata,
    input  logic [DATA_W-1:0]       ram_rdata
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ACK_ONE  = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] gnt;
    logic             gnt_we;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Search starts just after the last granted requester, so the previous winner goes last.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick_vld = 1'b0;
        pick_idx = last;
        cand     = last;
        for (int k = 0; k < N_REQ; k++) begin
            cand = wrap_inc(cand);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last      <= LAST_RST;
            gnt       <= '0;
            gnt_we    <= 1'b0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win && pick_vld) begin
                        gnt       <= pick_idx;
                        gnt_we    <= we[pick_idx];
                        ram_addr  <= addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        ram_we    <= we[pick_idx];
                        ram_wdata <= wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_we <= 1'b0;
                    state  <= WAIT;
                end
                // RAM output for the ACCESS address is valid during WAIT.
                WAIT: begin
                    ack <= ACK_ONE << gnt;
                    if (!gnt_we) begin
                        rdata <= ram_rdata;
                    end
                    state <= RESP;
                end
                RESP: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    last  <= gnt;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_map_ram_arbiter.sv
// Bench for map_ram_arbiter: directed steps plus randomized traffic against a map model.
module tb_map_ram_arbiter;
    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          win     = 1'b0;
    logic [N-1:0]  req     = '0;
    logic [N-1:0]  we      = '0;
    logic [N*AW-1:0] addr  = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]  ack;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic          bd_we   = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int we_cycles   = 0;
    int exp_last    = N - 1;
    logic [DW-1:0] exp_rdata = '0;
    logic [N-1:0]  ack_seen;
    int            ack_cyc;

    map_ram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .win       (win),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port map RAM with a bench-side preload port.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_cycles     <= we_cycles + 1;
        end
        if (bd_we) mem[bd_addr] <= bd_data;
        ram_rdata <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_addr    = a;
        bd_data    = d;
        bd_we      = 1'b1;
        ref_mem[a] = d;
        step();
        bd_we = 1'b0;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
    endtask

    task automatic rand_fields(input int i);
        set_req(i, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
    endtask

    // Winner is the requesting index with the smallest rotational distance past the last grant.
    function automatic int model_pick(input logic [N-1:0] r, input int l);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N + 1;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                d = (i - l - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // Called during an IDLE cycle with win=1 and req!=0; returns in the following IDLE cycle.
    task automatic txn(input bit drop_win);
        int            g;
        logic [AW-1:0] a;
        logic          wr;
        logic [DW-1:0] d;
        g  = model_pick(req, exp_last);
        a  = addr[g*AW +: AW];
        wr = we[g];
        d  = wdata[g*DW +: DW];
        step();
        chk("access_busy", busy, 1);
        chk("access_addr", ram_addr, a);
        chk("access_we", ram_we, wr);
        if (wr) chk("access_wdata", ram_wdata, d);
        chk("access_ack", ack, 0);
        if (drop_win) win = 1'b0;
        step();
        chk("wait_we", ram_we, 0);
        chk("wait_ack", ack, 0);
        chk("wait_busy", busy, 1);
        step();
        if (wr) ref_mem[a] = d;
        else exp_rdata = ref_mem[a];
        ack_seen = ack;
        ack_cyc  = cyc;
        chk("resp_ack", ack, 32'(1) << g);
        chk("resp_rdata", rdata, exp_rdata);
        chk("resp_busy", busy, 1);
        exp_last = g;
        step();
        chk("idle_ack", ack, 0);
        chk("idle_busy", busy, 0);
        chk("idle_we", ram_we, 0);
    endtask

    initial begin
        int order [6];
        int prev_cyc;
        int we_before;
        int n;
        logic [AW-1:0] hold_addr;
        order = '{0, 1, 2, 0, 1, 2};
        prev_cyc = 0;

        // Reset held with all requests up; map preloaded meanwhile.
        win = 1'b1;
        req = 3'b111;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'($urandom), '0);
        for (int a = 0; a < 256; a++) begin
            bd_write(AW'(a), DW'($urandom));
            chk("rst_ack", ack, 0);
            chk("rst_we", ram_we, 0);
            chk("rst_busy", busy, 0);
        end
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", ram_addr, 0);

        // Release: round-robin from requester 0, one transaction per 4 cycles.
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            txn(1'b0);
            chk("rr_order", ack_seen, 32'(1) << order[k]);
            if (k > 0) chk("rr_period", ack_cyc - prev_cyc, 4);
            prev_cyc = ack_cyc;
        end

        // Single read of a preloaded cell.
        req = '0;
        we  = '0;
        bd_write(8'h2A, 4'h5);
        set_req(1, 1'b0, 8'h2A, 4'h0);
        req = 3'b010;
        txn(1'b0);
        chk("read_ack", ack_seen, 3'b010);
        chk("read_data", rdata, 4'h5);

        // Single write, then read it back.
        req = 3'b100;
        set_req(2, 1'b1, 8'h10, 4'h9);
        we_before = we_cycles;
        txn(1'b0);
        chk("write_ack", ack_seen, 3'b100);
        chk("write_we_cycles", we_cycles - we_before, 1);
        req = 3'b001;
        set_req(0, 1'b0, 8'h10, 4'h0);
        we_before = we_cycles;
        txn(1'b0);
        chk("readback", rdata, 4'h9);
        chk("read_we_cycles", we_cycles - we_before, 0);

        // Window closed: request waits, no RAM activity.
        win = 1'b0;
        set_req(0, 1'b0, 8'h21, 4'h0);
        hold_addr = ram_addr;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("gate_busy", busy, 0);
            chk("gate_we", ram_we, 0);
            chk("gate_addr", ram_addr, hold_addr);
        end
        win = 1'b1;
        txn(1'b0);
        chk("gate_grant", ack_seen, 3'b001);
        req = 3'b010;
        set_req(1, 1'b1, 8'h22, 4'h7);
        txn(1'b1);
        chk("dropwin_ack", ack_seen, 3'b010);
        win = 1'b1;

        // Randomized traffic over a small address range so reads hit earlier writes.
        req = 3'b111;
        for (int i = 0; i < N; i++) rand_fields(i);
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(3) == 0) begin
                win = 1'b0;
                n = $urandom_range(5, 1);
                for (int c = 0; c < n; c++) begin
                    step();
                    chk("rgap_busy", busy, 0);
                    chk("rgap_ack", ack, 0);
                end
                win = 1'b1;
            end
            txn($urandom_range(3) == 0);
            win = 1'b1;
            req[exp_last] = 1'($urandom_range(1));
            rand_fields(exp_last);
            if (req == '0) begin
                n = $urandom_range(N - 1);
                req[n] = 1'b1;
                rand_fields(n);
            end
        end

        // Drain pending requests, then reset during WAIT of a write.
        for (int i = 0; i < N && req != '0; i++) begin
            txn(1'b0);
            req[exp_last] = 1'b0;
        end
        req = 3'b100;
        set_req(2, 1'b1, 8'h33, 4'hC);
        step();
        chk("mid_access_we", ram_we, 1);
        chk("mid_access_addr", ram_addr, 8'h33);
        step();
        ref_mem[8'h33] = 4'hC;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_rdata", rdata, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mid_hold_ack", ack, 0);
            chk("mid_hold_we", ram_we, 0);
        end
        exp_last  = N - 1;
        exp_rdata = '0;
        req = 3'b111;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'($urandom_range(15)), '0);
        #2;
        reset_n = 1'b1;
        txn(1'b0);
        chk("post_rst_grant", ack_seen, 3'b001);

        // Map contents must match every completed write.
        req = '0;
        step();
        for (int a = 0; a < 256; a++) chk("map_cell", mem[a], ref_mem[a]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
